fp19_div_seq: RTL and testbench
===============================

// Module: fp19_div_seq
// PURPOSE
//  Iterative divider for the 19-bit float format (sign[18], exp[17:10] bias 127, mant[9:0]).
//  Inverse operation of the combinational fp19 multiplier; radix-2 restoring, one quotient bit/clk.
//  Sits beside the multiplier in the interpolator datapath; valid/ready on both sides.
//  Flag and result conventions match the multiplier.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MAN_W   10   stored mantissa width (hidden bit implicit)
//  BIAS    127  exponent bias
//  QBITS   MAN_W+3 (=13)  quotient bits generated; fixes iteration count
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   a/b valid
//  in_ready    out  1   high only in IDLE
//  a           in   19  dividend
//  b           in   19  divisor
//  out_valid   out  1   result/flags valid; held until out_ready
//  out_ready   in   1   consumer accepts
//  result      out  19  quotient
//  exception   out  1   a or b exponent == 8'hFF
//  div_by_zero out  1   b is zero, no exception
//  overflow    out  1   biased exp >= 255
//  underflow   out  1   biased exp <= 0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, out_valid=0, result=0, all flags=0, counter/remainder=0.
//  FSM: IDLE -(in_valid&in_ready)-> CALC -(QBITS iterations)-> PACK -> DONE -(out_valid&out_ready)-> IDLE.
//  Latency fixed: out_valid rises on the 14th rising edge after the accepting edge, all operand classes.
//  in_ready=1 only in IDLE; an input can't be accepted in the cycle DONE is left (ready next cycle).
//  Operands captured on accept; later a/b changes ignored. out_ready in non-DONE states ignored.
//  Outputs registered; result/flags stable while out_valid=1 and out_ready=0.
//  Operand class: exp==0 -> zero (flush-to-zero, mantissa ignored); else mX={1,mant}, 11 bits.
//  Mantissa: q=floor((ma<<12)/mb), 13 bits, rem=remainder; sticky=|rem.
//   q[12]=1: m=q[11:2], g=q[1], s=q[0]|sticky, n=0;  q[12]=0: m=q[10:1], g=q[0], s=sticky, n=1.
//   Round up iff g&s (same rule as multiplier). Carry out of m: m=0, exp+1.
//  Exponent: signed 10-bit e = ea - eb + BIAS - n (+ round carry).
//  sign = a[18]^b[18] in all non-exception cases.
//  Priority in PACK: exception -> 19'd0; div_by_zero -> {sign,18'd0}; a zero -> {sign,18'd0}, no flags;
//   overflow (e>=255) -> {sign,18'd0}; underflow (e<=0) -> {sign,18'd0}; else {sign,e[7:0],m}.
//  Exactly one flag set, per priority above (0/0 -> div_by_zero; Inf exp on either -> exception only).
// STRUCTURE
//  Shared package fp19_pkg: EXP_W, MAN_W, BIAS, total width, is_zero/is_exc functions, FSM state enum.
//  Sub-module mant_div_iter: restoring shift/subtract core (load, step, q, rem, done).
//  Top holds the FSM, operand capture, classification, PACK rounding/exponent/flag logic.
// TESTING
//  6.0/2.0: a=0x20600 b=0x20000 -> result 0x20200, no flags, out_valid 14 clks after accept.
//  1.0/3.0: a=0x1FC00 b=0x20200 -> 0x1F555; -1.0/3.0: a=0x5FC00 -> 0x5F555.
//  a=0x3FC00 b=0x1FC00 -> exception=1, result 0; a=0x1FC00 b=0x00000 -> div_by_zero=1, result 0.
//  Overflow a=0x3F800 b=0x00400 -> overflow=1, result 0; underflow a=0x00400 b=0x3F800 -> underflow=1.
//  Backpressure: out_ready low 5 clks -> out_valid, result stable, in_ready=0; accept next op after.
//  rst_n low mid-CALC (iteration 6) -> immediate IDLE, out_valid=0; next op gives correct result.

Source files
------------

// File: rtl/fp19_pkg.sv
// Shared definitions for the fp19 arithmetic blocks: field widths, operand
// classification helpers and the divider FSM encoding.
package fp19_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 10;
    localparam int BIAS  = 127;
    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int QBITS = MAN_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_PACK,
        ST_DONE
    } state_t;

    // Zero exponent is treated as zero regardless of mantissa (flush-to-zero).
    function automatic logic is_zero(input logic [FP_W-1:0] x);
        return x[FP_W-2:MAN_W] == '0;
    endfunction

    function automatic logic is_exc(input logic [FP_W-1:0] x);
        return &x[FP_W-2:MAN_W];
    endfunction

endpackage

// File: rtl/mant_div_iter.sv
// Radix-2 restoring divider core: one quotient bit per step, MSB first.
// q = floor((dividend << (QB-1)) / divisor); rem holds the final remainder doubled.
module mant_div_iter #(
    parameter int DW = 11,
    parameter int QB = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [QB-1:0] q,
    output logic [DW:0]   rem,
    output logic          done
);

    localparam int CW = $clog2(QB + 1);
    localparam logic [CW-1:0] LAST = CW'(QB - 1);

    logic [DW:0]   r;
    logic [DW-1:0] d;
    logic [CW-1:0] cnt;
    logic          ge;
    logic [DW:0]   nr;

    assign ge   = r >= {1'b0, d};
    assign nr   = ge ? (r - {1'b0, d}) : r;
    assign rem  = r;
    // Asserted during the step that produces the final quotient bit.
    assign done = step && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            d   <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            r   <= {1'b0, dividend};
            d   <= divisor;
            q   <= '0;
            cnt <= '0;
        end else if (step) begin
            r   <= nr << 1;
            q   <= {q[QB-2:0], ge};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp19_div_seq.sv
// Sequential fp19 divider: captures operands, runs the mantissa core for QBITS
// cycles, then rounds, forms the exponent and resolves flags in PACK.
module fp19_div_seq
    import fp19_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result,
    output logic            exception,
    output logic            div_by_zero,
    output logic            overflow,
    output logic            underflow
);

    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] E_MAX = EW'(2**EXP_W - 1);

    state_t state, state_n;

    logic             accept, calc, last;
    logic             sign_r, exc_r, bz_r, az_r;
    logic [EXP_W-1:0] ea_r, eb_r;
    logic [QBITS-1:0] q;
    logic [MAN_W+1:0] rem;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_ready && in_valid;
    assign calc     = (state == ST_CALC);

    mant_div_iter #(.DW(MAN_W + 1), .QB(QBITS)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (calc),
        .dividend ({1'b1, a[MAN_W-1:0]}),
        .divisor  ({1'b1, b[MAN_W-1:0]}),
        .q        (q),
        .rem      (rem),
        .done     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (in_valid)  state_n = ST_CALC;
            ST_CALC: if (last)      state_n = ST_PACK;
            ST_PACK:                state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default:                state_n = ST_IDLE;
        endcase
    end

    // Normalise, round (g & s) and build the exponent from the raw quotient.
    logic             hi, g, s, carry;
    logic [MAN_W-1:0] m_t, m_f;
    logic [MAN_W:0]   m_rnd;
    logic [EW-1:0]    e_u;
    logic [FP_W-1:0]  res_n;
    logic             f_exc, f_dbz, f_ovf, f_unf;

    always_comb begin
        hi    = q[QBITS-1];
        m_t   = hi ? q[QBITS-2:2] : q[QBITS-3:1];
        g     = hi ? q[1] : q[0];
        s     = hi ? (q[0] | (|rem)) : (|rem);
        m_rnd = {1'b0, m_t} + {{MAN_W{1'b0}}, g & s};
        carry = m_rnd[MAN_W];
        m_f   = carry ? '0 : m_rnd[MAN_W-1:0];
        e_u   = {2'b00, ea_r} - {2'b00, eb_r} + EW'(BIAS)
              - {{(EW-1){1'b0}}, ~hi} + {{(EW-1){1'b0}}, carry};

        res_n = {sign_r, {(FP_W-1){1'b0}}};
        f_exc = 1'b0;
        f_dbz = 1'b0;
        f_ovf = 1'b0;
        f_unf = 1'b0;
        if (exc_r) begin
            res_n = '0;
            f_exc = 1'b1;
        end else if (bz_r) begin
            f_dbz = 1'b1;
        end else if (az_r) begin
            f_dbz = 1'b0;
        end else if ($signed(e_u) >= E_MAX) begin
            f_ovf = 1'b1;
        end else if ($signed(e_u) <= 0) begin
            f_unf = 1'b1;
        end else begin
            res_n = {sign_r, e_u[EXP_W-1:0], m_f};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r      <= 1'b0;
            exc_r       <= 1'b0;
            bz_r        <= 1'b0;
            az_r        <= 1'b0;
            ea_r        <= '0;
            eb_r        <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            exception   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // Mantissas go straight into the core; only sign/exp/class kept here.
            if (accept) begin
                sign_r <= a[FP_W-1] ^ b[FP_W-1];
                exc_r  <= is_exc(a) || is_exc(b);
                bz_r   <= is_zero(b);
                az_r   <= is_zero(a);
                ea_r   <= a[FP_W-2:MAN_W];
                eb_r   <= b[FP_W-2:MAN_W];
            end
            if (state == ST_PACK) begin
                out_valid   <= 1'b1;
                result      <= res_n;
                exception   <= f_exc;
                div_by_zero <= f_dbz;
                overflow    <= f_ovf;
                underflow   <= f_unf;
            end else if (state == ST_DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp19_div_seq.sv
// Randomised and directed checks of fp19_div_seq against an integer-arithmetic
// reference of the quotient, rounding, exponent and flag rules.
module tb_fp19_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [18:0] a = '0, b = '0;
    logic        in_ready, out_valid;
    logic [18:0] result;
    logic        exception, div_by_zero, overflow, underflow;

    int n_chk = 0;
    int n_pass = 0;

    fp19_div_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .exception(exception), .div_by_zero(div_by_zero),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // flags = {exception, div_by_zero, overflow, underflow}
    task automatic ref_div(input logic [18:0] x, input logic [18:0] y,
                           output logic [18:0] res, output logic [3:0] fl);
        int ea, eb, ma, mb, num, q, r, m, g, s, n, c, e;
        logic sg;
        ea = int'(x[17:10]);
        eb = int'(y[17:10]);
        sg = x[18] ^ y[18];
        res = {sg, 18'd0};
        fl  = 4'b0000;
        if (ea == 255 || eb == 255) begin
            res = '0;
            fl  = 4'b1000;
        end else if (eb == 0) begin
            fl = 4'b0100;
        end else if (ea != 0) begin
            ma  = 1024 + int'(x[9:0]);
            mb  = 1024 + int'(y[9:0]);
            num = ma * 4096;
            q   = num / mb;
            r   = num % mb;
            if (q >= 4096) begin
                m = (q / 4) % 1024; g = (q / 2) % 2; s = ((q % 2) != 0 || r != 0) ? 1 : 0; n = 0;
            end else begin
                m = (q / 2) % 1024; g = q % 2; s = (r != 0) ? 1 : 0; n = 1;
            end
            c = 0;
            if (g == 1 && s == 1) m = m + 1;
            if (m == 1024) begin m = 0; c = 1; end
            e = ea - eb + 127 - n + c;
            if (e >= 255)     fl = 4'b0010;
            else if (e <= 0)  fl = 4'b0001;
            else              res = {sg, 8'(e), 10'(m)};
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [18:0] x, input logic [18:0] y, input int hold);
        logic [18:0] er, held;
        logic [3:0]  ef;
        int lat;
        ref_div(x, y, er, ef);
        check("in_ready_idle", in_ready, 1);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 19'($urandom); b = 19'($urandom);
        lat = 0;
        while (!out_valid && lat <= 40) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check("latency", lat, 14);
        check("result", result, er);
        check("flags", {exception, div_by_zero, overflow, underflow}, ef);
        if (lat > 40) begin
            pulse_reset();
            return;
        end
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 19'($urandom);
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1);
            check("stall_result", result, held);
            check("stall_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("released", out_valid, 0);
        check("ready_after", in_ready, 1);
    endtask

    function automatic logic [18:0] gen_fp();
        logic [7:0] e;
        case ($urandom_range(0, 15))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'd1;
            3:       e = 8'd254;
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    initial begin
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {exception, div_by_zero, overflow, underflow}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", in_ready, 1);

        run_op(19'h20600, 19'h20000, 0);
        check("dir_6div2", result, 19'h20200);
        run_op(19'h1FC00, 19'h20200, 1);
        check("dir_1div3", result, 19'h1F555);
        run_op(19'h5FC00, 19'h20200, 0);
        check("dir_m1div3", result, 19'h5F555);
        run_op(19'h3FC00, 19'h1FC00, 0);
        check("dir_exc", exception, 1);
        run_op(19'h1FC00, 19'h00000, 0);
        check("dir_dbz", div_by_zero, 1);
        run_op(19'h00000, 19'h00000, 0);
        run_op(19'h3F800, 19'h00400, 0);
        check("dir_ovf", overflow, 1);
        run_op(19'h00400, 19'h3F800, 5);
        check("dir_unf", underflow, 1);

        // Reset in the middle of CALC must abort the operation cleanly.
        a = 19'h20600; b = 19'h20000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(19'h1FC00, 19'h20200, 0);

        for (int i = 0; i < 60; i++)
            run_op(gen_fp(), gen_fp(), int'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
